stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have input clk (1 bit): the system clock, with all state updated on its rising edge.
REQ-002 The block SHALL have input rstn (1 bit): reset, asynchronous, active-low.
REQ-003 The block SHALL have input tick (1 bit): a single-cycle count-enable pulse from an external prescaler.
REQ-004 The block SHALL have input btn_ss (1 bit): a start/stop request, pre-debounced and lasting one cycle.
REQ-005 The block SHALL have input btn_clr (1 bit): a clear request, pre-debounced and lasting one cycle.
REQ-006 The block SHALL have input btn_lap (1 bit): a lap request, pre-debounced and lasting one cycle.
REQ-007 The block SHALL have output disp (16 bits): four BCD digits, with [3:0] least significant.
REQ-008 The block SHALL have output state (2 bits): IDLE=00, RUN=01, PAUSE=10, LAP=11.
REQ-009 The block SHALL have output running (1 bit): high when state is RUN or LAP.
REQ-010 The block SHALL have output ovf (1 bit): a one-cycle pulse when the count wraps from 9999 to 0000.

Function
REQ-011 The internal count SHALL be four cascaded mod-10 digits, d0..d3, with each digit in the range 0-9.
REQ-012 The count SHALL increment by 1 on a rising edge where state is RUN or LAP and tick=1; otherwise it SHALL hold.
REQ-013 A digit at 9 SHALL wrap to 0 and carry into the next digit; count 9999 + 1 SHALL give 0000 and assert ovf for exactly that cycle.
REQ-014 Button priority SHALL be btn_clr > btn_ss > btn_lap, with the lower-priority requests ignored in the same cycle.
REQ-015 btn_clr in any state SHALL set the count to 0000 and the state to IDLE next cycle, overriding any coincident tick increment and ovf.
REQ-016 btn_ss SHALL cause these transitions: IDLE->RUN, RUN->PAUSE, PAUSE->RUN, LAP->PAUSE.
REQ-017 A tick coincident with btn_ss SHALL use the pre-transition state, so IDLE+start does not count and RUN+stop does count.
REQ-018 btn_lap SHALL be handled as defined in REQ-027/028, and SHALL be ignored in IDLE and PAUSE.
REQ-019 disp SHALL equal the live count in every state except LAP; outputs SHALL derive only from registers, with no combinational path from inputs.
REQ-020 running and state SHALL change on the same edge as the transition.

Reset
REQ-021 rstn low SHALL immediately force the count and the lap latch to 0000, the state to IDLE, disp to 0x0000, and running and ovf to 0.
REQ-022 Reset assertion mid-count or in LAP SHALL abandon all progress, with no partial digit update.
REQ-023 After rstn deasserts, the first transition SHALL require btn_ss.

Configuration
REQ-024 The macro STOPWATCH_LAP_EN SHALL compile the lap feature in.
REQ-025 With STOPWATCH_LAP_EN defined, the block SHALL contain a 16-bit lap register and the LAP state.
REQ-026 Without STOPWATCH_LAP_EN, btn_lap SHALL have no effect, state SHALL never equal 11, disp SHALL always equal the live count, and no lap register SHALL exist.
REQ-027 With STOPWATCH_LAP_EN, btn_lap in RUN SHALL latch the current (pre-increment) count into the lap register and enter LAP, where disp shows the lap register while counting continues.
REQ-028 With STOPWATCH_LAP_EN, btn_lap in LAP SHALL return to RUN and disp SHALL resume the live count next cycle.

Verification
REQ-029 Reset, btn_ss, 23 ticks, btn_ss -> state=PAUSE, disp=0x0023, running=0; further ticks leave disp at 0x0023.
REQ-030 Preload count to 9998 via ticks, then 2 ticks in RUN -> disp 0x9999 then 0x0000, ovf high for exactly one cycle.
REQ-031 In RUN at 0x0041, btn_clr together with tick and btn_ss in one cycle -> next cycle disp=0x0000, state=IDLE, ovf=0.
REQ-032 With LAP_EN: RUN at 0x0107, btn_lap, then 5 ticks -> disp=0x0107, state=11; btn_lap -> disp=0x0112.
REQ-033 Without LAP_EN: RUN with btn_lap pulses and ticks -> state stays 01 and disp tracks the live count.
REQ-034 Assert rstn low mid-RUN at 0x0555 between clock edges -> disp=0x0000 and state=IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stopwatch_if.sv
// stopwatch_if: control inputs and display outputs of stopwatch_ctrl.
// master drives the buttons and tick; slave is the stopwatch itself.
interface stopwatch_if;
    logic        tick;
    logic        btn_ss;
    logic        btn_clr;
    logic        btn_lap;
    logic [15:0] disp;
    logic [1:0]  state;
    logic        running;
    logic        ovf;

    modport master (
        output tick, btn_ss, btn_clr, btn_lap,
        input  disp, state, running, ovf
    );

    modport slave (
        input  tick, btn_ss, btn_clr, btn_lap,
        output disp, state, running, ovf
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: four-digit BCD stopwatch with start/stop, clear and optional lap hold.
// Define STOPWATCH_LAP_EN to build in the lap register and the LAP state.
module stopwatch_ctrl (
    input logic        clk,
    input logic        rstn,
    stopwatch_if.slave sw
);
`ifdef STOPWATCH_LAP_EN
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
`endif
    state_t      st, st_nx;
    logic [15:0] cnt, cnt_inc;
    logic        wrap, counting, run_st;

    // RUN and LAP are the only encodings with bit 0 set
    assign run_st   = st[0];
    assign counting = run_st && sw.tick;

    always_comb begin
        logic carry;
        carry = 1'b1;
        cnt_inc = cnt;
        for (int i = 0; i < 4; i++) begin
            cnt_inc[i*4 +: 4] = carry ? (cnt[i*4 +: 4] == 4'd9 ? 4'd0 : cnt[i*4 +: 4] + 4'd1) : cnt[i*4 +: 4];
            carry = carry && (cnt[i*4 +: 4] == 4'd9);
        end
        wrap = carry;
    end

    always_comb begin
        st_nx = st;
        if (sw.btn_clr)
            st_nx = IDLE;
        else if (sw.btn_ss)
            st_nx = run_st ? PAUSE : RUN;
`ifdef STOPWATCH_LAP_EN
        else if (sw.btn_lap)
            st_nx = st == RUN ? LAP : st == LAP ? RUN : st;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st     <= IDLE;
            cnt    <= 16'h0000;
            sw.ovf <= 1'b0;
        end else begin
            st     <= st_nx;
            cnt    <= sw.btn_clr ? 16'h0000 : counting ? cnt_inc : cnt;
            sw.ovf <= !sw.btn_clr && counting && wrap;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [15:0] lap_q;

    // Capture the count as it stands before this edge's increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            lap_q <= 16'h0000;
        else if (!sw.btn_clr && !sw.btn_ss && sw.btn_lap && st == RUN)
            lap_q <= cnt;
    end

    assign sw.disp = st == LAP ? lap_q : cnt;
`else
    logic unused_lap;
    assign unused_lap = sw.btn_lap;
    assign sw.disp    = cnt;
`endif

    assign sw.state   = st;
    assign sw.running = run_st;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed vector table plus multi-cycle sequences for stopwatch_ctrl.
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    stopwatch_if sw ();
    stopwatch_ctrl dut (.clk(clk), .rstn(rstn), .sw(sw.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic        tick, ss, clr, lap;
        logic [15:0] disp;
        logic [1:0]  state;
        logic        running, ovf;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [15:0] d, input logic [1:0] s, input logic r, input logic o);
        chk({name, ".disp"}, sw.disp, d);
        chk({name, ".state"}, {14'd0, sw.state}, {14'd0, s});
        chk({name, ".running"}, {15'd0, sw.running}, {15'd0, r});
        chk({name, ".ovf"}, {15'd0, sw.ovf}, {15'd0, o});
    endtask

    task automatic cyc(input logic t, input logic ss, input logic clr, input logic lap);
        @(negedge clk);
        sw.tick = t; sw.btn_ss = ss; sw.btn_clr = clr; sw.btn_lap = lap;
        @(posedge clk);
        #1;
        sw.tick = 0; sw.btn_ss = 0; sw.btn_clr = 0; sw.btn_lap = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    initial begin
        sw.tick = 0; sw.btn_ss = 0; sw.btn_clr = 0; sw.btn_lap = 0;
        //          tick ss clr lap  disp     state  run ovf
        vecs[0]  = '{0, 0, 0, 0, 16'h0000, 2'b00, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 16'h0000, 2'b00, 0, 0};
        vecs[2]  = '{1, 1, 0, 0, 16'h0000, 2'b01, 1, 0};
        vecs[3]  = '{1, 0, 0, 0, 16'h0001, 2'b01, 1, 0};
        vecs[4]  = '{1, 0, 0, 0, 16'h0002, 2'b01, 1, 0};
        vecs[5]  = '{1, 1, 0, 0, 16'h0003, 2'b10, 0, 0};
        vecs[6]  = '{1, 0, 0, 0, 16'h0003, 2'b10, 0, 0};
        vecs[7]  = '{0, 0, 0, 1, 16'h0003, 2'b10, 0, 0};
        vecs[8]  = '{0, 1, 0, 0, 16'h0003, 2'b01, 1, 0};
        vecs[9]  = '{1, 1, 1, 0, 16'h0000, 2'b00, 0, 0};
        vecs[10] = '{0, 1, 0, 0, 16'h0000, 2'b01, 1, 0};
        vecs[11] = '{0, 1, 0, 1, 16'h0000, 2'b10, 0, 0};
        vecs[12] = '{0, 0, 1, 0, 16'h0000, 2'b00, 0, 0};

        #12;
        chk_all("reset_hold", 16'h0000, 2'b00, 0, 0);
        rstn = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].tick, vecs[i].ss, vecs[i].clr, vecs[i].lap);
            chk_all($sformatf("vec%0d", i), vecs[i].disp, vecs[i].state, vecs[i].running, vecs[i].ovf);
        end

        // pause holds the count
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        ticks(23);
        cyc(0, 1, 0, 0);
        chk_all("pause23", 16'h0023, 2'b10, 0, 0);
        ticks(5);
        chk_all("pause23_hold", 16'h0023, 2'b10, 0, 0);

        // wrap from 9999
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        ticks(9998);
        chk_all("pre9998", 16'h9998, 2'b01, 1, 0);
        cyc(1, 0, 0, 0);
        chk_all("at9999", 16'h9999, 2'b01, 1, 0);
        cyc(1, 0, 0, 0);
        chk_all("wrap", 16'h0000, 2'b01, 1, 1);
        cyc(0, 0, 0, 0);
        chk_all("wrap_after", 16'h0000, 2'b01, 1, 0);

        // clear wins over tick and start/stop
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        ticks(41);
        chk("at41", sw.disp, 16'h0041);
        cyc(1, 1, 1, 0);
        chk_all("clr_prio", 16'h0000, 2'b00, 0, 0);

`ifdef STOPWATCH_LAP_EN
        cyc(0, 1, 0, 0);
        ticks(107);
        cyc(0, 0, 0, 1);
        chk_all("lap_enter", 16'h0107, 2'b11, 1, 0);
        ticks(5);
        chk_all("lap_hold", 16'h0107, 2'b11, 1, 0);
        cyc(0, 0, 0, 1);
        chk_all("lap_exit", 16'h0112, 2'b01, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(1, 1, 0, 0);
        chk_all("lap_stop", 16'h0113, 2'b10, 0, 0);
`else
        cyc(0, 1, 0, 0);
        ticks(3);
        cyc(0, 0, 0, 1);
        chk_all("nolap1", 16'h0003, 2'b01, 1, 0);
        cyc(1, 0, 0, 1);
        chk_all("nolap2", 16'h0004, 2'b01, 1, 0);
        cyc(1, 0, 0, 1);
        chk_all("nolap3", 16'h0005, 2'b01, 1, 0);
`endif

        // asynchronous reset mid-run
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        ticks(555);
        chk("at555", sw.disp, 16'h0555);
        sw.tick = 1;
        #2;
        rstn = 1'b0;
        #1;
        chk_all("async_rst", 16'h0000, 2'b00, 0, 0);
        sw.tick = 0;
        @(negedge clk);
        rstn = 1'b1;
        ticks(3);
        chk_all("post_rst_idle", 16'h0000, 2'b00, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk_all("post_rst_run", 16'h0001, 2'b01, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
